// File: rtl/m3_sopc_pio_led_if.sv
// m3_sopc_pio_led_if: Avalon-MM s1 slave bus bundle
// carrying chipselect, write strobe, address, write and read data.
interface m3_sopc_pio_led_if;
    logic        chipselect;
    logic        write_n;
    logic [2:0]  address;
    logic [31:0] writedata;
    logic [31:0] readdata;

    modport master (
        output chipselect,
        output write_n,
        output address,
        output writedata,
        input  readdata
    );

    modport slave (
        input  chipselect,
        input  write_n,
        input  address,
        input  writedata,
        output readdata
    );
endinterface

// File: rtl/m3_sopc_pio_led.sv
// m3_sopc_pio_led: LED output PIO with set/clear aliases
// and a hardware blink engine that XOR-toggles masked bits.
module m3_sopc_pio_led #(
    parameter int                 WIDTH       = 10,
    parameter int                 PERIOD_W    = 24,
    parameter logic [WIDTH-1:0]   RESET_VALUE = '0
) (
    input  logic             clk,
    input  logic             reset,
    m3_sopc_pio_led_if.slave s1,
    output logic [WIDTH-1:0] out_port
);

    logic [WIDTH-1:0]    r_data;
    logic [WIDTH-1:0]    r_mask;
    logic [PERIOD_W-1:0] r_period;
    logic [PERIOD_W-1:0] r_cnt;
    logic                r_phase;

    logic                w_wr;
    logic                w_wr_data;
    logic                w_wr_mask;
    logic                w_wr_period;
    logic                w_wr_set;
    logic                w_wr_clr;
    logic [WIDTH-1:0]    w_wd;
    logic [31:0]         w_rd;
    logic                w_unused;

    assign w_wr        = s1.chipselect & ~s1.write_n;
    assign w_wr_data   = w_wr & (s1.address == 3'd0);
    assign w_wr_mask   = w_wr & (s1.address == 3'd2);
    assign w_wr_period = w_wr & (s1.address == 3'd3);
    assign w_wr_set    = w_wr & (s1.address == 3'd4);
    assign w_wr_clr    = w_wr & (s1.address == 3'd5);
    assign w_wd        = s1.writedata[WIDTH-1:0];
    assign w_unused    = ^s1.writedata;

    // LED drive is derived from registered state only
    assign out_port = r_data ^ (r_mask & {WIDTH{r_phase}});

    // data register with plain, set and clear write paths
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_data <= RESET_VALUE;
        end else if (w_wr_data) begin
            r_data <= w_wd;
        end else if (w_wr_set) begin
            r_data <= r_data | w_wd;
        end else if (w_wr_clr) begin
            r_data <= r_data & ~w_wd;
        end
    end

    // blink mask and half-period configuration registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_mask   <= '0;
            r_period <= '0;
        end else begin
            if (w_wr_mask) begin
                r_mask <= w_wd;
            end
            if (w_wr_period) begin
                r_period <= s1.writedata[PERIOD_W-1:0];
            end
        end
    end

    // blink prescaler; a period write restarts the half-period
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt   <= '0;
            r_phase <= 1'b0;
        end else if (w_wr_period || (r_period == '0)) begin
            r_cnt   <= '0;
            r_phase <= 1'b0;
        end else if (r_cnt == r_period - PERIOD_W'(1)) begin
            r_cnt   <= '0;
            r_phase <= ~r_phase;
        end else begin
            r_cnt <= r_cnt + PERIOD_W'(1);
        end
    end

    // read mux, zero-extended; reserved and write-only slots read 0
    always_comb begin
        w_rd = '0;
        case (s1.address)
            3'd0:    w_rd = 32'(r_data);
            3'd1:    w_rd = 32'(out_port);
            3'd2:    w_rd = 32'(r_mask);
            3'd3:    w_rd = 32'(r_period);
            default: w_rd = '0;
        endcase
    end

    // readdata registered every clock for a fixed latency of one
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1.readdata <= '0;
        end else begin
            s1.readdata <= w_rd;
        end
    end

endmodule

// File: tb/tb_m3_sopc_pio_led.sv
// tb_m3_sopc_pio_led: randomized and directed bench for the
// LED PIO against a timeline-based reference model.
module tb_m3_sopc_pio_led;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [9:0] out_port;

    m3_sopc_pio_led_if bus ();

    m3_sopc_pio_led #(
        .WIDTH       (10),
        .PERIOD_W    (24),
        .RESET_VALUE (10'h155)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .s1       (bus.slave),
        .out_port (out_port)
    );

    always #5 clk = ~clk;

    logic [9:0]  m_data;
    logic [9:0]  m_mask;
    logic [23:0] m_per;
    int unsigned m_k;
    int          n_tests = 0;
    int          n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic m_phase();
        if (m_per == 24'd0) return 1'b0;
        return ((m_k / int'(m_per)) % 2) == 1;
    endfunction

    function automatic logic [9:0] m_out();
        return m_data ^ (m_mask & {10{m_phase()}});
    endfunction

    function automatic logic [31:0] m_read(input logic [2:0] a);
        case (a)
            3'd0:    return {22'd0, m_data};
            3'd1:    return {22'd0, m_out()};
            3'd2:    return {22'd0, m_mask};
            3'd3:    return {8'd0, m_per};
            default: return 32'd0;
        endcase
    endfunction

    task automatic m_reset();
        m_data = 10'h155;
        m_mask = 10'h000;
        m_per  = 24'd0;
        m_k    = 0;
    endtask

    task automatic cyc(input logic cs, input logic wn,
                       input logic [2:0] a, input logic [31:0] wd);
        logic [31:0] erd;
        bus.chipselect = cs;
        bus.write_n    = wn;
        bus.address    = a;
        bus.writedata  = wd;
        @(posedge clk);
        erd = m_read(a);
        m_k++;
        if (cs && !wn) begin
            case (a)
                3'd0: m_data = wd[9:0];
                3'd2: m_mask = wd[9:0];
                3'd3: begin m_per = wd[23:0]; m_k = 0; end
                3'd4: m_data = m_data | wd[9:0];
                3'd5: m_data = m_data & ~wd[9:0];
                default: ;
            endcase
        end
        #1;
        check("out_port", {22'd0, out_port}, {22'd0, m_out()});
        check("readdata", bus.readdata, erd);
    endtask

    task automatic idle(input int n, input logic [2:0] a);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b1, a, $urandom);
    endtask

    initial begin
        bus.chipselect = 1'b0;
        bus.write_n    = 1'b1;
        bus.address    = 3'd0;
        bus.writedata  = 32'd0;
        m_reset();
        repeat (3) @(posedge clk);
        #1;
        check("rst_out", {22'd0, out_port}, 32'h155);
        check("rst_rd", bus.readdata, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        cyc(1'b0, 1'b1, 3'd2, 32'd0);
        cyc(1'b0, 1'b1, 3'd3, 32'd0);
        check("rst_per_rd", bus.readdata, 32'd0);

        cyc(1'b1, 1'b0, 3'd0, 32'h3A5);
        #1 reset = 1'b1;
        #1;
        m_reset();
        check("async_out", {22'd0, out_port}, 32'h155);
        check("async_rd", bus.readdata, 32'd0);
        @(negedge clk);
        reset = 1'b0;

        cyc(1'b1, 1'b0, 3'd0, 32'h0F0);
        check("set0", {22'd0, out_port}, 32'h0F0);
        cyc(1'b1, 1'b0, 3'd4, 32'h00F);
        check("set1", {22'd0, out_port}, 32'h0FF);
        cyc(1'b1, 1'b0, 3'd5, 32'h0C0);
        check("clr", {22'd0, out_port}, 32'h03F);
        cyc(1'b1, 1'b1, 3'd0, 32'd0);
        check("rd_data", bus.readdata, 32'h3F);
        cyc(1'b0, 1'b1, 3'd4, 32'd0);
        check("rd_outset", bus.readdata, 32'd0);

        cyc(1'b1, 1'b0, 3'd0, 32'd0);
        cyc(1'b1, 1'b0, 3'd2, 32'h003);
        cyc(1'b1, 1'b0, 3'd3, 32'd4);
        idle(3, 3'd1);
        check("blink_hold", {22'd0, out_port}, 32'h000);
        idle(1, 3'd1);
        check("blink_tog", {22'd0, out_port}, 32'h003);
        idle(16, 3'd1);

        cyc(1'b1, 1'b0, 3'd3, 32'd1);
        idle(6, 3'd1);
        cyc(1'b1, 1'b0, 3'd3, 32'd1);
        cyc(1'b0, 1'b1, 3'd1, 32'd0);
        check("p1_phase", {22'd0, out_port}, 32'h003);
        cyc(1'b1, 1'b0, 3'd3, 32'd0);
        check("p0_off", {22'd0, out_port}, 32'h000);
        idle(5, 3'd1);

        cyc(1'b1, 1'b0, 3'd3, 32'd8);
        idle(5, 3'd1);
        cyc(1'b1, 1'b0, 3'd3, 32'd8);
        idle(3, 3'd1);
        cyc(1'b1, 1'b0, 3'd2, 32'h00C);
        idle(3, 3'd1);
        check("restart_hold", {22'd0, out_port}, 32'h000);
        idle(1, 3'd1);
        check("restart_tog", {22'd0, out_port}, 32'h00C);
        idle(10, 3'd1);

        cyc(1'b1, 1'b0, 3'd3, 32'd0);
        cyc(1'b1, 1'b0, 3'd0, 32'hFFFFFFFF);
        cyc(1'b1, 1'b1, 3'd0, 32'd0);
        check("wide_rd", bus.readdata, 32'h3FF);
        cyc(1'b1, 1'b0, 3'd6, 32'd0);
        cyc(1'b1, 1'b0, 3'd7, 32'd0);
        cyc(1'b0, 1'b0, 3'd0, 32'd0);
        cyc(1'b1, 1'b1, 3'd5, 32'h3FF);
        cyc(1'b1, 1'b1, 3'd0, 32'd0);
        check("ignored_rd", bus.readdata, 32'h3FF);

        for (int i = 0; i < 600; i++) begin
            logic [2:0]  a;
            logic [31:0] wd;
            a  = 3'($urandom_range(0, 7));
            wd = $urandom;
            if (a == 3'd3) wd = {wd[31:24], 24'($urandom_range(0, 6))};
            cyc($urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0, a, wd);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
